// File: rtl/soc_system_sysid_pkg.sv
// Shared constants for the extended system-ID slave: register offsets,
// capability-word layout and legal parameter ranges.
package soc_system_sysid_pkg;

  // Register word offsets
  localparam int REG_SYS_ID    = 0;
  localparam int REG_TIMESTAMP = 1;
  localparam int REG_CAPS      = 2;
  localparam int REG_SCRATCH   = 3;
  localparam int REG_UPTIME_LO = 4;
  localparam int REG_UPTIME_HI = 5;
  localparam int REG_USER_BASE = 8;

  // Capability word layout
  localparam logic [15:0] CAPS_SIGNATURE    = 16'h5359;
  localparam int          CAPS_NUM_USER_LSB = 0;
  localparam int          CAPS_LATENCY_LSB  = 4;
  localparam int          CAPS_ADDR_W_LSB   = 8;
  localparam int          CAPS_SIG_LSB      = 16;

  // Legal parameter ranges
  localparam int MAX_USER_WORDS   = 8;
  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 3;

  // Builds the read-only capability word from the build options.
  function automatic logic [31:0] caps_word(input int num_user, input int latency,
                                            input int addr_w);
    logic [31:0] w;
    w = '0;
    w[CAPS_NUM_USER_LSB +: 4] = 4'(num_user);
    w[CAPS_LATENCY_LSB  +: 2] = 2'(latency);
    w[CAPS_ADDR_W_LSB   +: 4] = 4'(addr_w);
    w[CAPS_SIG_LSB      +: 16] = CAPS_SIGNATURE;
    return w;
  endfunction

endpackage

// File: rtl/soc_system_sysid_rdpipe.sv
// Fixed-depth valid/data delay line for read responses. Data is forced to
// zero on stages that carry no valid response, so the output bus is quiet
// whenever out_valid is low. Reset flushes every stage.
module soc_system_sysid_rdpipe #(
  parameter int LATENCY = 1,
  parameter int W       = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LATENCY-1:0] vld;
  logic [W-1:0]       dat [LATENCY];

  // Shift valid and data one stage per clock; stage 0 captures the accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld <= '0;
      // NOTE: every stage is cleared so a response in flight at reset can never emerge afterwards.
      for (int k = 0; k < LATENCY; k++) dat[k] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int k = 1; k < LATENCY; k++) begin
        vld[k] <= vld[k-1];
        dat[k] <= dat[k-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/soc_system_sysid_ext.sv
// Extended system-identification slave for the lightweight bridge: ID and
// timestamp constants, capability word, scratch register, 64-bit uptime
// counter with coherent high-word snapshot, board user-info words and a
// pipelined read response.
module soc_system_sysid_ext
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] SYS_ID         = 32'hACD5_CD02,
  parameter logic [31:0] TIMESTAMP      = 32'h5289_0E66,
  parameter int          NUM_USER_WORDS = 4,
  parameter int          ADDR_W         = 4,
  parameter int          READ_LATENCY   = 1,
  // A zero-word build still gets a one-word port so the bus is never empty.
  localparam int         USER_W         = (NUM_USER_WORDS > 0) ? 32 * NUM_USER_WORDS : 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic [USER_W-1:0] user_info,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  // Build-option sanity checks
  if (NUM_USER_WORDS < 0 || NUM_USER_WORDS > MAX_USER_WORDS) begin : g_bad_user_words
    $error("NUM_USER_WORDS out of range 0..8");
  end
  if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("READ_LATENCY out of range 1..3");
  end
  if (ADDR_W < 1 || ADDR_W > 30 || (1 << ADDR_W) < REG_USER_BASE + NUM_USER_WORDS) begin : g_bad_addr_w
    $error("ADDR_W too small for the register map");
  end

  localparam logic [31:0] CAPS = caps_word(NUM_USER_WORDS, READ_LATENCY, ADDR_W);

  logic [31:0] addr_w;
  logic        rd_accept;
  logic        wr_scratch;
  logic [31:0] scratch;
  logic [63:0] uptime;
  logic [31:0] hi_shadow;
  logic [31:0] rd_data;

  // A simultaneous write wins; the read is dropped and never answered.
  assign addr_w     = 32'(address);
  assign rd_accept  = read && !write;
  assign wr_scratch = write && (addr_w == 32'(REG_SCRATCH));

  // Register-map decode of the read data sampled in the accept cycle.
  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    case (addr_w)
      32'(REG_SYS_ID):    rd_data = SYS_ID;
      32'(REG_TIMESTAMP): rd_data = TIMESTAMP;
      32'(REG_CAPS):      rd_data = CAPS;
      32'(REG_SCRATCH):   rd_data = scratch;
      32'(REG_UPTIME_LO): rd_data = uptime[31:0];
      32'(REG_UPTIME_HI): rd_data = hi_shadow;
      default: begin
        for (int k = 0; k < NUM_USER_WORDS; k++) begin
          if (addr_w == 32'(REG_USER_BASE + k)) rd_data = user_info[32*k +: 32];
        end
      end
    endcase
  end

  // Scratch register with per-byte-lane write enables.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch <= '0;
    end else if (wr_scratch) begin
      for (int b = 0; b < 4; b++) begin
        // NOTE: non-blocking for all sequential state so readers in the same edge see the old value.
        if (byteenable[b]) scratch[8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  // Free-running uptime counter; wraps naturally at 2^64.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) uptime <= '0;
    else       uptime <= uptime + 64'd1;
  end

  // Snapshot the high word whenever the low word is read, so a following
  // high-word read pairs with it even if the low word has since wrapped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                          hi_shadow <= '0;
    else if (rd_accept && addr_w == 32'(REG_UPTIME_LO)) hi_shadow <= uptime[63:32];
  end

  soc_system_sysid_rdpipe #(
    .LATENCY (READ_LATENCY),
    .W       (32)
  ) u_rdpipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rd_accept),
    .in_data   (rd_data),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// Bench for soc_system_sysid_ext: three instances (read latency 1, 2, 3)
// share one stimulus stream; each response is predicted by a register-map
// model and matched against the instance's own due cycle.
module tb_soc_system_sysid_ext;

  localparam logic [31:0] SYS_ID = 32'hACD5_CD02;
  localparam logic [31:0] TS     = 32'h5289_0E66;
  localparam int          NU     = 4;
  localparam int          AW     = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [3:0]    byteenable = '0;
  logic [127:0]  user_info = '0;
  logic [31:0]   rdata [3];
  logic          rvld  [3];

  soc_system_sysid_ext #(.NUM_USER_WORDS(NU), .ADDR_W(AW), .READ_LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .user_info(user_info),
    .readdata(rdata[0]), .readdatavalid(rvld[0]));
  soc_system_sysid_ext #(.NUM_USER_WORDS(NU), .ADDR_W(AW), .READ_LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .user_info(user_info),
    .readdata(rdata[1]), .readdatavalid(rvld[1]));
  soc_system_sysid_ext #(.NUM_USER_WORDS(NU), .ADDR_W(AW), .READ_LATENCY(3)) u_l3 (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .user_info(user_info),
    .readdata(rdata[2]), .readdatavalid(rvld[2]));

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  exp_t        q [3][$];
  logic [63:0] m_cnt;
  logic [31:0] m_hi;
  logic [31:0] m_scr;
  int          cyc;
  int          checks;
  int          failures;
  vec_t        tbl [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // What the register map says a read of word a returns right now.
  function automatic logic [31:0] mdl_read(input int a, input int lat);
    if (a == 0) return SYS_ID;
    if (a == 1) return TS;
    if (a == 2) return 32'h5359_0000 + 32'(AW * 256 + lat * 16 + NU);
    if (a == 3) return m_scr;
    if (a == 4) return m_cnt[31:0];
    if (a == 5) return m_hi;
    if (a >= 8 && a < 8 + NU) return user_info[(a - 8) * 32 +: 32];
    return 32'h0;
  endfunction

  // Every instance must show exactly the response due this cycle, or nothing.
  task automatic compare_outputs();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() > 0 && q[i][0].due == cyc) begin
        e = q[i].pop_front();
        check($sformatf("lat%0d_rsp", i + 1), {31'b0, rvld[i], rdata[i]}, {31'b0, 1'b1, e.d});
      end else begin
        check($sformatf("lat%0d_idle", i + 1), {31'b0, rvld[i], rdata[i]}, 64'h0);
      end
    end
  endtask

  // Drive one bus cycle from a negedge, advance the model, check after the edge.
  task automatic step(input logic rd, input logic wr, input logic [3:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    if (rd && !wr) begin
      for (int i = 0; i < 3; i++) begin
        e.d   = mdl_read(int'(a), i + 1);
        e.due = cyc + i + 1;
        q[i].push_back(e);
      end
    end
    if (wr && a == 4'd3)
      for (int b = 0; b < 4; b++) if (be[b]) m_scr[8*b +: 8] = wd[8*b +: 8];
    if (rd && !wr && a == 4'd4) m_hi = m_cnt[63:32];
    m_cnt = m_cnt + 64'd1;
    @(posedge clock);
    cyc++;
    #1;
    compare_outputs();
    read = 1'b0; write = 1'b0;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
  endtask

  // Assert reset mid-cycle, require quiet outputs, release on a negedge.
  task automatic do_reset();
    reset = 1'b1; read = 1'b0; write = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lat%0d_in_reset", i + 1), {31'b0, rvld[i], rdata[i]}, 64'h0);
      q[i].delete();
    end
    m_cnt = '0; m_hi = '0; m_scr = '0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++)
      check($sformatf("lat%0d_held_reset", i + 1), {31'b0, rvld[i], rdata[i]}, 64'h0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] got_lo;
    int          r;
    logic        rd_r, wr_r;
    logic [3:0]  a_r;
    logic        prev_lo;

    checks = 0; failures = 0; cyc = 0;
    m_cnt = '0; m_hi = '0; m_scr = '0;
    user_info = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};

    // Directed vectors; expectations are for the latency-1 instance.
    tbl[0]  = '{1'b1, 1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 32'hACD5_CD02};
    tbl[1]  = '{1'b1, 1'b0, 4'd1,  32'h0,         4'h0, 1'b1, 32'h5289_0E66};
    tbl[2]  = '{1'b1, 1'b0, 4'd2,  32'h0,         4'h0, 1'b1, 32'h5359_0414};
    tbl[3]  = '{1'b0, 1'b1, 4'd3,  32'hDEAD_BEEF, 4'h5, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 4'd3,  32'h0,         4'h0, 1'b1, 32'h00AD_00EF};
    tbl[5]  = '{1'b0, 1'b1, 4'd0,  32'h1234_5678, 4'hF, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 32'hACD5_CD02};
    tbl[7]  = '{1'b1, 1'b0, 4'd15, 32'h0,         4'h0, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 4'd6,  32'h0,         4'h0, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 4'd3,  32'h1122_3344, 4'hF, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 4'd3,  32'h0,         4'h0, 1'b1, 32'h1122_3344};
    tbl[11] = '{1'b1, 1'b0, 4'd8,  32'h0,         4'h0, 1'b1, 32'h1111_0000};
    tbl[12] = '{1'b1, 1'b0, 4'd11, 32'h0,         4'h0, 1'b1, 32'h1111_0003};
    tbl[13] = '{1'b1, 1'b0, 4'd12, 32'h0,         4'h0, 1'b1, 32'h0};

    @(negedge clock);
    do_reset();

    // Counter reads 0 in the first cycle after reset release.
    step(1'b1, 1'b0, 4'd4, 32'h0, 4'h0);
    check("uptime_first", {32'h0, rdata[0]}, 64'h0);
    idle(3);

    for (int k = 0; k < 14; k++) begin
      step(tbl[k].rd, tbl[k].wr, tbl[k].a, tbl[k].wd, tbl[k].be);
      check($sformatf("tbl_%0d", k), {31'b0, rvld[0], rdata[0]}, {31'b0, tbl[k].exp_v, tbl[k].exp_d});
    end
    idle(3);

    // Coherent 64-bit uptime across a low-word wrap.
    force u_l1.uptime = 64'h0000_0001_FFFF_FFFF;
    force u_l2.uptime = 64'h0000_0001_FFFF_FFFF;
    force u_l3.uptime = 64'h0000_0001_FFFF_FFFF;
    #1;
    release u_l1.uptime;
    release u_l2.uptime;
    release u_l3.uptime;
    m_cnt = 64'h0000_0001_FFFF_FFFF;
    step(1'b1, 1'b0, 4'd4, 32'h0, 4'h0);
    got_lo = rdata[0];
    check("uptime_lo_wrap", {32'h0, got_lo}, 64'h0000_0000_FFFF_FFFF);
    step(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    check("uptime_hi_shadow", {32'h0, rdata[0]}, 64'h0000_0000_0000_0001);
    idle(3);

    // Back-to-back pipelined reads; latency-3 instance returns them in order.
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
    step(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
    step(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);
    step(1'b1, 1'b0, 4'd8, 32'h0, 4'h0);
    check("lat3_burst_first", {31'b0, rvld[2], rdata[2]}, {31'b0, 1'b1, 32'h5289_0E66});
    idle(4);

    // Reset while a read is in flight: its response must never appear.
    step(1'b1, 1'b0, 4'd0, 32'h0, 4'h0);
    do_reset();
    idle(4);

    // Randomized traffic against the model.
    user_info = {$urandom, $urandom, $urandom, $urandom};
    prev_lo = 1'b0;
    for (int k = 0; k < 400; k++) begin
      r    = int'($urandom_range(0, 9));
      rd_r = (r < 6);
      wr_r = (r >= 5 && r < 8);
      a_r  = 4'($urandom_range(0, 15));
      if (wr_r && $urandom_range(0, 1) == 1) a_r = 4'd3;
      if (prev_lo && $urandom_range(0, 1) == 1) begin
        rd_r = 1'b1; wr_r = 1'b0; a_r = 4'd5;
      end
      prev_lo = rd_r && !wr_r && a_r == 4'd4;
      step(rd_r, wr_r, a_r, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(4);
    check("queues_drained", 64'(q[0].size() + q[1].size() + q[2].size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
